// File: rtl/hazard_pkg.sv
// Shared state, opcode and forward-select constants for the pipeline hazard unit.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_e;

  localparam int unsigned OPCODE_W = 4;
  localparam int unsigned FWD_W    = 2;

  localparam logic [OPCODE_W-1:0] OP_NOP   = 4'b0000;
  localparam logic [OPCODE_W-1:0] OP_STORE = 4'b0001;
  localparam logic [OPCODE_W-1:0] OP_LOAD  = 4'b0111;

  localparam logic [FWD_W-1:0] FWD_RF = 2'b00;
  localparam logic [FWD_W-1:0] FWD_M  = 2'b10;
  localparam logic [FWD_W-1:0] FWD_WB = 2'b01;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive data-memory wait cycles; expired flags the watchdog limit.
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic advance,
  input  logic clear,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);

  logic [CNT_W-1:0] cnt;

  // start loads 1 because the cycle that opens the wait is itself a stall cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= CNT_W'(1);
    end else if (clear) begin
      cnt <= '0;
    end else if (advance) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expired = (cnt == CNT_W'(MEM_TIMEOUT));

endmodule

// File: rtl/hazard_unit.sv
// Stall/flush/forward sequencer for the 5-stage core with a memory-wait watchdog.
// Define HAZARD_FWD_EN to enable EX-stage operand forwarding.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int unsigned REGADDRWIDTH = 4,
  parameter int unsigned MEM_TIMEOUT  = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [REGADDRWIDTH-1:0] srcAD,
  input  logic [REGADDRWIDTH-1:0] srcBD,
  input  logic                    usesAD,
  input  logic                    usesBD,
  input  logic [REGADDRWIDTH-1:0] srcAE,
  input  logic [REGADDRWIDTH-1:0] srcBE,
  input  logic [OPCODE_W-1:0]     opcodeE,
  input  logic [REGADDRWIDTH-1:0] destE,
  input  logic [REGADDRWIDTH-1:0] destM,
  input  logic [REGADDRWIDTH-1:0] destWB,
  input  logic                    writeEnableE,
  input  logic                    writeEnableM,
  input  logic                    writeEnableWB,
  input  logic                    branchTakenE,
  input  logic                    memReqM,
  input  logic                    memReadyM,
  output logic                    stallF,
  output logic                    stallD,
  output logic                    stallE,
  output logic                    stallM,
  output logic                    flushD,
  output logic                    flushE,
  output logic [FWD_W-1:0]        forwardAE,
  output logic [FWD_W-1:0]        forwardBE,
  output logic                    haltFlag
);

  state_e state, next_state;
  logic   tmr_start, tmr_advance, tmr_clear, tmr_expired;
  logic   raw_stall;
  logic   [FWD_W-1:0] fwd_a, fwd_b;

  function automatic logic d_reads(
    input logic                    uses_a,
    input logic [REGADDRWIDTH-1:0] src_a,
    input logic                    uses_b,
    input logic [REGADDRWIDTH-1:0] src_b,
    input logic [REGADDRWIDTH-1:0] dest
  );
    return (uses_a && (src_a == dest)) || (uses_b && (src_b == dest));
  endfunction

`ifdef HAZARD_FWD_EN
  function automatic logic [FWD_W-1:0] fwd_sel(
    input logic [REGADDRWIDTH-1:0] src,
    input logic                    we_m,
    input logic [REGADDRWIDTH-1:0] dst_m,
    input logic                    we_wb,
    input logic [REGADDRWIDTH-1:0] dst_wb
  );
    if (we_m && (dst_m == src))        return FWD_M;
    else if (we_wb && (dst_wb == src)) return FWD_WB;
    else                               return FWD_RF;
  endfunction

  // Only a load in E cannot be forwarded in time; everything else bypasses
  assign raw_stall = (opcodeE == OP_LOAD) && writeEnableE &&
                     d_reads(usesAD, srcAD, usesBD, srcBD, destE);
  assign fwd_a = fwd_sel(srcAE, writeEnableM, destM, writeEnableWB, destWB);
  assign fwd_b = fwd_sel(srcBE, writeEnableM, destM, writeEnableWB, destWB);
`else
  // Without bypass paths any pending E or M write to a D source must drain first
  assign raw_stall = (writeEnableE && d_reads(usesAD, srcAD, usesBD, srcBD, destE)) ||
                     (writeEnableM && d_reads(usesAD, srcAD, usesBD, srcBD, destM));
  assign fwd_a = FWD_RF;
  assign fwd_b = FWD_RF;

  logic unused_ok;
  assign unused_ok = ^{srcAE, srcBE, destWB, writeEnableWB, opcodeE};
`endif

  mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst),
    .start   (tmr_start),
    .advance (tmr_advance),
    .clear   (tmr_clear),
    .expired (tmr_expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state  = state;
    tmr_start   = 1'b0;
    tmr_advance = 1'b0;
    tmr_clear   = 1'b0;
    stallF      = 1'b0;
    stallD      = 1'b0;
    stallE      = 1'b0;
    stallM      = 1'b0;
    flushD      = 1'b0;
    flushE      = 1'b0;
    haltFlag    = 1'b0;
    forwardAE   = fwd_a;
    forwardBE   = fwd_b;

    case (state)
      RUN: begin
        if (memReqM && !memReadyM) begin
          {stallF, stallD, stallE, stallM} = 4'b1111;
          tmr_start  = 1'b1;
          next_state = MEM_WAIT;
        end else if (branchTakenE) begin
          flushD = 1'b1;
          flushE = 1'b1;
        end else if (raw_stall) begin
          stallF = 1'b1;
          stallD = 1'b1;
          flushE = 1'b1;
        end
      end
      MEM_WAIT: begin
        // A withdrawn request releases the pipe exactly like an acknowledge
        if (!memReqM || memReadyM) begin
          tmr_clear  = 1'b1;
          next_state = RUN;
        end else begin
          {stallF, stallD, stallE, stallM} = 4'b1111;
          if (tmr_expired) begin
            next_state = HALT;
          end else begin
            tmr_advance = 1'b1;
          end
        end
      end
      HALT: begin
        {stallF, stallD, stallE, stallM} = 4'b1111;
        haltFlag = 1'b1;
      end
      default: begin
        next_state = RUN;
      end
    endcase

    // Reset holds bubbles in D/E with the pipe free-running
    if (!rst) begin
      {stallF, stallD, stallE, stallM} = 4'b0000;
      flushD    = 1'b1;
      flushE    = 1'b1;
      haltFlag  = 1'b0;
      forwardAE = FWD_RF;
      forwardBE = FWD_RF;
    end
  end

endmodule
